register_file: RTL

//  Architectural register file with rename tags, sitting directly downstream of the reorder buffer.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file.sv | 101 ++++++++++
 2 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
package register_file_pkg;

   localparam int REG_NUM  = 32;
   localparam int REG_ID_W = 5;

   typedef logic [REG_ID_W-1:0] reg_id_t;
   typedef logic [31:0]         reg_val_t;

   localparam reg_id_t ZERO_REG = '0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Architectural register file with rename tags: ROB commits update values and
// clear matching tags, issue claims destinations, flush drops all pending tags.
module register_file
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,
   input  logic                 issue_ready,
   input  logic [4:0]           issue_rd_id,
   input  logic [ROB_WIDTH-1:0] issue_rob_index,
   input  logic [4:0]           rs1_id,
   output logic                 rs1_busy,
   output logic [31:0]          rs1_val,
   output logic [ROB_WIDTH-1:0] rs1_rob_index,
   input  logic [4:0]           rs2_id,
   output logic                 rs2_busy,
   output logic [31:0]          rs2_val,
   output logic [ROB_WIDTH-1:0] rs2_rob_index,
   input  logic                 commit_ready,
   input  logic [4:0]           commit_reg_id,
   input  logic [31:0]          commit_reg_val,
   input  logic [ROB_WIDTH-1:0] commit_rob_index
);

   reg_val_t             val_q  [REG_NUM];
   logic                 busy_q [REG_NUM];
   logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];

   logic commit_en;
   logic commit_clears_tag;

   assign commit_en         = rdy_in && commit_ready && (commit_reg_id != ZERO_REG);
   assign commit_clears_tag = busy_q[commit_reg_id] && (tag_q[commit_reg_id] == commit_rob_index);

   // NOTE: the value array is reset explicitly because x-reads after reset must
   // return 0; that costs a reset net on every storage bit, which is accepted here.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int r = 0; r < REG_NUM; r++) val_q[r] <= '0;
      end else if (commit_en) begin
         val_q[commit_reg_id] <= commit_reg_val;
      end
   end

   // NOTE: non-blocking assignments make the later issue/flush writes override the
   // earlier commit clear for the same entry, giving issue priority within a cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int r = 0; r < REG_NUM; r++) begin
            busy_q[r] <= 1'b0;
            tag_q[r]  <= '0;
         end
      end else if (rdy_in) begin
         if (commit_en && commit_clears_tag) busy_q[commit_reg_id] <= 1'b0;
         if (clr_in) begin
            for (int r = 0; r < REG_NUM; r++) busy_q[r] <= 1'b0;
         end else if (issue_ready && issue_rd_id != ZERO_REG) begin
            busy_q[issue_rd_id] <= 1'b1;
            tag_q[issue_rd_id]  <= issue_rob_index;
         end
      end
   end

   // Two identical read ports; a commit that retires the current tag is forwarded.
   logic [4:0]           rd_id   [2];
   logic                 rd_busy [2];
   logic [31:0]          rd_val  [2];
   logic [ROB_WIDTH-1:0] rd_tag  [2];

   assign rd_id[0] = rs1_id;
   assign rd_id[1] = rs2_id;

   for (genvar p = 0; p < 2; p++) begin : g_read
      always_comb begin
         rd_busy[p] = busy_q[rd_id[p]];
         rd_val[p]  = val_q[rd_id[p]];
         rd_tag[p]  = tag_q[rd_id[p]];
         if (rd_id[p] == ZERO_REG) begin
            rd_busy[p] = 1'b0;
            rd_val[p]  = '0;
            rd_tag[p]  = '0;
         end else if (commit_ready && commit_reg_id == rd_id[p] && busy_q[rd_id[p]] &&
                      tag_q[rd_id[p]] == commit_rob_index) begin
            rd_busy[p] = 1'b0;
            rd_val[p]  = commit_reg_val;
         end
      end
   end

   assign rs1_busy      = rd_busy[0];
   assign rs1_val       = rd_val[0];
   assign rs1_rob_index = rd_tag[0];
   assign rs2_busy      = rd_busy[1];
   assign rs2_val       = rd_val[1];
   assign rs2_rob_index = rd_tag[1];

endmodule : register_file
